// File: rtl/data_cache_dm.sv
// data_cache_dm: direct-mapped, write-back, write-allocate data cache.
// Hits complete in the same cycle. A miss optionally writes the dirty victim
// line back, refills the line one word per memory ack, and then completes the
// request in a single RESPOND cycle.
// Optional feature macro: DCACHE_STATS_EN adds the hit_cnt_o/miss_cnt_o counters.
module data_cache_dm #(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  read_write_sel_i,
    output logic [31:0] read_data_o,
    output logic        busy_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int IDX_W   = $clog2(LINES);
    localparam int OFF_W   = $clog2(WORDS);
    localparam int TAG_LSB = IDX_W + OFF_W + 2;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int AW      = IDX_W + OFF_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_e;
    typedef enum logic [3:0] {
        OP_NOP, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } op_e;

    state_e             state_q, state_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [31:0]        data_q [LINES*WORDS];
    logic [TAG_W-1:0]   tag_q  [LINES];

    op_e                op;
    logic               is_load, is_store, misaligned, req_ok, hit, access;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic [31:0]        rd_word, rd_shift, load_val, st_data, st_mask;
    logic [15:0]        rd_half;
    logic               arr_we, tag_we;
    logic [AW-1:0]      arr_addr;
    logic [31:0]        arr_wdata;
    logic               last_word;

    assign req_tag   = address_i[31:TAG_LSB];
    assign req_idx   = address_i[TAG_LSB-1:OFF_W+2];
    assign req_off   = address_i[OFF_W+1:2];
    assign rd_word   = data_q[{req_idx, req_off}];
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign last_word = (cnt_q == OFF_W'(WORDS - 1));

    // Decode the request code, its alignment and the load/store data lanes.
    // NOTE: every combinational output gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        op = OP_NOP;
        if (read_write_sel_i[3]) begin
            case (read_write_sel_i[2:0])
                3'b000:  op = OP_LB;
                3'b001:  op = OP_LH;
                3'b010:  op = OP_LW;
                3'b011:  op = OP_SB;
                3'b100:  op = OP_LBU;
                3'b101:  op = OP_LHU;
                3'b110:  op = OP_SH;
                3'b111:  op = OP_SW;
                default: op = OP_NOP;
            endcase
        end
        is_load    = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                     (op == OP_LBU) || (op == OP_LHU);
        is_store   = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        misaligned = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && address_i[0]) ||
                     (((op == OP_LW) || (op == OP_SW)) && (address_i[1:0] != 2'b00));
        req_ok     = rst_i && (op != OP_NOP) && !misaligned;

        rd_shift = rd_word >> {address_i[1:0], 3'b000};
        rd_half  = address_i[1] ? rd_word[31:16] : rd_word[15:0];
        case (op)
            OP_LB:   load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            OP_LBU:  load_val = {24'h0, rd_shift[7:0]};
            OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_val = {16'h0, rd_half};
            OP_LW:   load_val = rd_word;
            default: load_val = 32'h0;
        endcase

        case (op)
            OP_SB: begin
                st_data = {4{write_data_i[7:0]}};
                st_mask = 32'h0000_00FF << {address_i[1:0], 3'b000};
            end
            OP_SH: begin
                st_data = {2{write_data_i[15:0]}};
                st_mask = address_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            end
            OP_SW: begin
                st_data = write_data_i;
                st_mask = 32'hFFFF_FFFF;
            end
            default: begin
                st_data = 32'h0;
                st_mask = 32'h0;
            end
        endcase
    end

    // Next-state, memory-port and array-write control for the miss FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        arr_we      = 1'b0;
        arr_addr    = {req_idx, req_off};
        arr_wdata   = rd_word;
        tag_we      = 1'b0;
        access      = 1'b0;
        busy_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;

        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (hit) begin
                        access = 1'b1;
                    end else begin
                        busy_o  = 1'b1;
                        cnt_d   = '0;
                        state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[req_idx], req_idx, cnt_q, 2'b00};
                mem_wdata_o = data_q[{req_idx, cnt_q}];
                if (mem_ack_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag, req_idx, cnt_q, 2'b00};
                if (mem_ack_i) begin
                    arr_we    = 1'b1;
                    arr_addr  = {req_idx, cnt_q};
                    arr_wdata = mem_rdata_i;
                    cnt_d     = cnt_q + 1'b1;
                    if (last_word) begin
                        cnt_d            = '0;
                        tag_we           = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        state_d          = RESPOND;
                    end
                end
            end
            RESPOND: begin
                access  = req_ok;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A completing access (hit or RESPOND) commits its store bytes here.
        if (access && is_store) begin
            arr_we           = 1'b1;
            arr_wdata        = (rd_word & ~st_mask) | (st_data & st_mask);
            dirty_d[req_idx] = 1'b1;
        end

        read_data_o = (access && is_load) ? load_val : 32'h0;
        misalign_o  = rst_i && (op != OP_NOP) && misaligned;
    end

    // FSM state, word counter and per-line valid/dirty bits.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tag arrays: refill words, store merges and the new tag.
    // NOTE: the arrays carry no reset; the cleared valid bits make their
    // contents irrelevant, and leaving them unreset allows RAM mapping.
    always_ff @(posedge clk_i) begin
        if (arr_we) begin
            data_q[arr_addr] <= arr_wdata;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Hits count in IDLE only; misses count on the IDLE exit into the miss FSM.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && req_ok) begin
            if (hit) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    // Statistic counter registers, wrapping naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
